// File: rtl/ppc_types.sv
// ppc_types: control struct for the add/sub pipe and the CR0 bit positions.
package ppc_types;

    typedef struct packed {
        logic subtract;
        logic use_carry;
        logic alter_ca;
        logic alter_ov;
        logic alter_cr0;
    } add_sub_pipe_ctrl_t;

    localparam int CR0_LT = 0;
    localparam int CR0_GT = 1;
    localparam int CR0_EQ = 2;
    localparam int CR0_SO = 3;

endpackage

// File: rtl/add_sub_pipeline_if.sv
// add_sub_pipeline_if: issue/result handshake bundle between the reservation station, the pipe and the result bus.
interface add_sub_pipeline_if #(
    parameter int WIDTH       = 32,
    parameter int RS_ID_WIDTH = 5
);
    import ppc_types::*;

    logic                   flush;
    logic                   input_valid;
    logic                   input_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_in;
    logic [4:0]             result_reg_addr_in;
    logic [0:WIDTH-1]       op1;
    logic [0:WIDTH-1]       op2;
    logic                   carry_in;
    logic                   so_in;
    add_sub_pipe_ctrl_t     control;
    logic                   output_valid;
    logic                   output_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_out;
    logic [4:0]             result_reg_addr_out;
    logic [0:WIDTH-1]       result;
    logic                   ca_out;
    logic                   ov_out;
    logic                   so_out;
    logic                   ca_we;
    logic                   ov_we;
    logic                   cr0_we;
    logic [0:3]             cr0;

    modport master (
        output flush, input_valid, rs_id_in, result_reg_addr_in, op1, op2, carry_in, so_in, control, output_ready,
        input  input_ready, output_valid, rs_id_out, result_reg_addr_out, result,
               ca_out, ov_out, so_out, ca_we, ov_we, cr0_we, cr0
    );

    modport slave (
        input  flush, input_valid, rs_id_in, result_reg_addr_in, op1, op2, carry_in, so_in, control, output_ready,
        output input_ready, output_valid, rs_id_out, result_reg_addr_out, result,
               ca_out, ov_out, so_out, ca_we, ov_we, cr0_we, cr0
    );

endinterface

// File: rtl/add_sub_core.sv
// add_sub_core: combinational PowerPC add/subtract-from with CA, OV, SO and CR0 (bit 0 is the MSB).
module add_sub_core
    import ppc_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [0:WIDTH-1] op1,
    input  logic [0:WIDTH-1] op2,
    input  logic             carry_in,
    input  logic             so_in,
    input  logic             subtract,
    input  logic             use_carry,
    input  logic             alter_ov,
    output logic [0:WIDTH-1] sum,
    output logic             ca,
    output logic             ov,
    output logic             so,
    output logic [0:3]       cr0
);
    logic [0:WIDTH-1] a;
    logic [WIDTH:0]   full;

    always_comb begin
        a = subtract ? ~op1 : op1;
        full = {1'b0, a} + {1'b0, op2} + {{WIDTH{1'b0}}, use_carry ? carry_in : subtract};
        sum = full[WIDTH-1:0];
        ca = full[WIDTH];
        // carry into the sign bit is recovered from the sign-bit sum
        ov = a[0] ^ op2[0] ^ sum[0] ^ ca;
        so = so_in | (alter_ov & ov);
        cr0[CR0_LT] = sum[0];
        cr0[CR0_GT] = ~sum[0] & (|sum);
        cr0[CR0_EQ] = ~(|sum);
        cr0[CR0_SO] = so;
    end

endmodule

// File: rtl/add_sub_pipeline.sv
// add_sub_pipeline: STAGES-deep add/sub execution pipe with bubble-collapsing backpressure and flush.
module add_sub_pipeline #(
    parameter int WIDTH       = 32,
    parameter int STAGES      = 2,
    parameter int RS_ID_WIDTH = 5
) (
    input logic              clk,
    input logic              rst,
    add_sub_pipeline_if.slave bus
);
    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]             rd;
        logic [0:WIDTH-1]       res;
        logic                   ca;
        logic                   ov;
        logic                   so;
        logic                   ca_we;
        logic                   ov_we;
        logic                   cr0_we;
        logic [0:3]             cr0;
    } payload_t;

    logic [0:WIDTH-1] core_sum;
    logic             core_ca;
    logic             core_ov;
    logic             core_so;
    logic [0:3]       core_cr0;
    payload_t         core_pl;
    payload_t         pl_q [STAGES];
    payload_t         pl_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;

    add_sub_core #(.WIDTH(WIDTH)) u_core (
        .op1       (bus.op1),
        .op2       (bus.op2),
        .carry_in  (bus.carry_in),
        .so_in     (bus.so_in),
        .subtract  (bus.control.subtract),
        .use_carry (bus.control.use_carry),
        .alter_ov  (bus.control.alter_ov),
        .sum       (core_sum),
        .ca        (core_ca),
        .ov        (core_ov),
        .so        (core_so),
        .cr0       (core_cr0)
    );

    always_comb begin
        core_pl = '{rs_id: bus.rs_id_in, rd: bus.result_reg_addr_in, res: core_sum,
                    ca: core_ca, ov: core_ov, so: core_so,
                    ca_we: bus.control.alter_ca, ov_we: bus.control.alter_ov,
                    cr0_we: bus.control.alter_cr0, cr0: core_cr0};
    end

    // a stage may move when any stage from it to the output is empty, or the output drains
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        assign adv[i] = bus.output_ready | ~(&valid_q[STAGES-1:i]);
        if (i == 0) begin : g_head
            assign valid_d[i] = ~bus.flush & (adv[i] ? (bus.input_valid & bus.input_ready) : valid_q[i]);
            assign pl_d[i]    = adv[i] ? core_pl : pl_q[i];
        end else begin : g_body
            assign valid_d[i] = ~bus.flush & (adv[i] ? valid_q[i-1] : valid_q[i]);
            assign pl_d[i]    = adv[i] ? pl_q[i-1] : pl_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) pl_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            pl_q    <= pl_d;
        end
    end

    assign bus.input_ready         = adv[0] & ~bus.flush;
    assign bus.output_valid        = valid_q[STAGES-1];
    assign bus.rs_id_out           = pl_q[STAGES-1].rs_id;
    assign bus.result_reg_addr_out = pl_q[STAGES-1].rd;
    assign bus.result              = pl_q[STAGES-1].res;
    assign bus.ca_out              = pl_q[STAGES-1].ca;
    assign bus.ov_out              = pl_q[STAGES-1].ov;
    assign bus.so_out              = pl_q[STAGES-1].so;
    assign bus.ca_we               = pl_q[STAGES-1].ca_we;
    assign bus.ov_we               = pl_q[STAGES-1].ov_we;
    assign bus.cr0_we              = pl_q[STAGES-1].cr0_we;
    assign bus.cr0                 = pl_q[STAGES-1].cr0;

endmodule

// File: tb/tb_add_sub_pipeline.sv
// tb_add_sub_pipeline: directed checks of arithmetic, flags, backpressure, flush and reset.
module tb_add_sub_pipeline;
    import ppc_types::*;

    localparam int STAGES_A = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    add_sub_pipeline_if #(.WIDTH(32), .RS_ID_WIDTH(5)) a_if ();
    add_sub_pipeline_if #(.WIDTH(32), .RS_ID_WIDTH(5)) b_if ();

    add_sub_pipeline #(.WIDTH(32), .STAGES(STAGES_A), .RS_ID_WIDTH(5)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    add_sub_pipeline #(.WIDTH(32), .STAGES(3), .RS_ID_WIDTH(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op_vec(input string tag, input logic [4:0] id, input logic [31:0] x, input logic [31:0] y,
                          input logic cin, input logic so, input logic [4:0] ctl, input logic [31:0] exp_res,
                          input logic [2:0] exp_flags, input logic [3:0] exp_cr0, input logic [2:0] exp_we);
        a_if.input_valid        = 1'b1;
        a_if.rs_id_in           = id;
        a_if.result_reg_addr_in = id + 5'd1;
        a_if.op1                = x;
        a_if.op2                = y;
        a_if.carry_in           = cin;
        a_if.so_in              = so;
        a_if.control            = add_sub_pipe_ctrl_t'(ctl);
        tick;
        a_if.input_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(a_if.output_valid), 64'(0));
        tick;
        chk({tag, "_valid"}, 64'(a_if.output_valid), 64'(1));
        chk({tag, "_tag"}, 64'(a_if.rs_id_out), 64'(id));
        chk({tag, "_rd"}, 64'(a_if.result_reg_addr_out), 64'(id + 5'd1));
        chk({tag, "_res"}, 64'(a_if.result), 64'(exp_res));
        chk({tag, "_ca_ov_so"}, 64'({a_if.ca_out, a_if.ov_out, a_if.so_out}), 64'(exp_flags));
        chk({tag, "_cr0"}, 64'(a_if.cr0), 64'(exp_cr0));
        chk({tag, "_we"}, 64'({a_if.ca_we, a_if.ov_we, a_if.cr0_we}), 64'(exp_we));
    endtask

    initial begin
        int         sent;
        int         recv;
        int         cnt;
        logic       stalled;
        logic [4:0] held_tag;
        logic [31:0] held_res;
        a_if.flush = 1'b0; a_if.input_valid = 1'b0; a_if.rs_id_in = '0; a_if.result_reg_addr_in = '0;
        a_if.op1 = '0; a_if.op2 = '0; a_if.carry_in = 1'b0; a_if.so_in = 1'b0; a_if.control = '0;
        a_if.output_ready = 1'b1;
        b_if.flush = 1'b0; b_if.input_valid = 1'b0; b_if.rs_id_in = '0; b_if.result_reg_addr_in = '0;
        b_if.op1 = '0; b_if.op2 = '0; b_if.carry_in = 1'b0; b_if.so_in = 1'b0; b_if.control = '0;
        b_if.output_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(a_if.output_valid), 64'(0));
        chk("rst_ready", 64'(a_if.input_ready), 64'(1));
        chk("rst_res", 64'(a_if.result), 64'(0));
        chk("rst_tag", 64'(a_if.rs_id_out), 64'(0));
        chk("rst_flags", 64'({a_if.ca_out, a_if.ov_out, a_if.so_out, a_if.ca_we, a_if.ov_we, a_if.cr0_we, a_if.cr0}), 64'(0));

        op_vec("subf",   5'd1, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, 5'b10101, 32'h0000_0002, 3'b100, 4'b0100, 3'b101);
        op_vec("add_ov", 5'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 5'b00011, 32'hFFFF_FFFE, 3'b011, 4'b1001, 3'b011);
        op_vec("adde",   5'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 5'b01101, 32'h0000_0000, 3'b100, 4'b0010, 3'b101);
        op_vec("add_nc", 5'd4, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 5'b00101, 32'hFFFF_FFFF, 3'b001, 4'b1001, 3'b101);
        op_vec("subfe",  5'd5, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 5'b11101, 32'hFFFF_FFFD, 3'b000, 4'b1000, 3'b101);
        tick;

        sent = 0; recv = 0; cnt = 0; stalled = 1'b0; held_tag = '0; held_res = '0;
        a_if.control = '0; a_if.so_in = 1'b0; a_if.carry_in = 1'b0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            a_if.input_valid  = (sent < 6);
            a_if.rs_id_in     = 5'(10 + sent);
            a_if.op1          = 32'(sent);
            a_if.op2          = 32'h100;
            a_if.output_ready = !(c >= 3 && c < 7);
            #1;
            chk("stream_in_ready", 64'(a_if.input_ready), 64'(!(cnt == STAGES_A && !a_if.output_ready)));
            if (stalled) begin
                chk("stall_valid", 64'(a_if.output_valid), 64'(1));
                chk("stall_tag", 64'(a_if.rs_id_out), 64'(held_tag));
                chk("stall_res", 64'(a_if.result), 64'(held_res));
            end
            if (a_if.output_valid && a_if.output_ready) begin
                chk("stream_order", 64'(a_if.rs_id_out), 64'(10 + recv));
                chk("stream_res", 64'(a_if.result), 64'(32'h100 + 32'(recv)));
                recv++;
                cnt--;
            end
            if (a_if.input_valid && a_if.input_ready) begin
                sent++;
                cnt++;
            end
            stalled  = a_if.output_valid && !a_if.output_ready;
            held_tag = a_if.rs_id_out;
            held_res = a_if.result;
            tick;
        end
        a_if.input_valid = 1'b0;
        chk("stream_count", 64'(recv), 64'(6));

        a_if.output_ready = 1'b0;
        a_if.input_valid  = 1'b1;
        a_if.rs_id_in     = 5'd20;
        tick;
        a_if.rs_id_in = 5'd21;
        tick;
        a_if.rs_id_in = 5'd22;
        a_if.flush    = 1'b1;
        #1;
        chk("flush_in_ready", 64'(a_if.input_ready), 64'(0));
        chk("full_valid", 64'(a_if.output_valid), 64'(1));
        chk("full_tag", 64'(a_if.rs_id_out), 64'(20));
        tick;
        a_if.flush        = 1'b0;
        a_if.rs_id_in     = 5'd23;
        a_if.output_ready = 1'b1;
        #1;
        chk("post_flush_valid", 64'(a_if.output_valid), 64'(0));
        chk("post_flush_ready", 64'(a_if.input_ready), 64'(1));
        tick;
        a_if.input_valid = 1'b0;
        chk("refill_lat1", 64'(a_if.output_valid), 64'(0));
        tick;
        chk("refill_valid", 64'(a_if.output_valid), 64'(1));
        chk("refill_tag", 64'(a_if.rs_id_out), 64'(23));
        tick;
        chk("refill_empty", 64'(a_if.output_valid), 64'(0));

        b_if.input_valid = 1'b1;
        b_if.op2         = 32'h10;
        for (int k = 1; k <= 3; k++) begin
            b_if.rs_id_in = 5'(k);
            b_if.op1      = 32'(k);
            tick;
        end
        b_if.input_valid = 1'b0;
        chk("s3_lat_valid", 64'(b_if.output_valid), 64'(1));
        chk("s3_lat_tag", 64'(b_if.rs_id_out), 64'(1));
        chk("s3_lat_res", 64'(b_if.result), 64'(32'h11));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("s3_rst_valid", 64'(b_if.output_valid), 64'(0));
        chk("s3_rst_tag", 64'(b_if.rs_id_out), 64'(0));
        chk("s3_rst_res", 64'(b_if.result), 64'(0));
        chk("s3_rst_cr0", 64'(b_if.cr0), 64'(0));
        chk("s3_rst_ready", 64'(b_if.input_ready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("s3_no_stale", 64'(b_if.output_valid), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
